speck32_iter_core: RTL and testbench

SPECK32_ITER_CORE -- requirements
Module: speck32_iter_core

---
 rtl/speck32_iter_core.sv | 132 +++++++++++++
 tb/tb_speck32_iter_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/speck32_iter_core.sv
// Iterative Speck32/64 encryptor: one round per clock, 22 rounds, valid/ready handshakes.
// Optional round_idx debug port is enabled by defining SPECK_ROUND_IDX_EN.

module speck_xor16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a ^ b;
endmodule

module speck32_iter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] pt_x,
    input  logic [15:0] pt_y,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] ct_x,
    output logic [15:0] ct_y
`ifdef SPECK_ROUND_IDX_EN
    ,
    output logic [4:0]  round_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ROUND = 5'd21;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] k_q, k_d;
    logic [15:0] l0_q, l0_d;
    logic [15:0] l1_q, l1_d;
    logic [15:0] l2_q, l2_d;
    logic [4:0]  r_q, r_d;

    // Round datapath: data round and key-schedule round evaluated side by side.
    logic [15:0] x_sum, l_sum, x_new, y_new, l_new, k_new;

    assign x_sum = {x_q[6:0], x_q[15:7]} + y_q;
    assign l_sum = {l0_q[6:0], l0_q[15:7]} + k_q;

    speck_xor16 u_xor_x (.a(x_sum),                     .b(k_q),             .y(x_new));
    speck_xor16 u_xor_y (.a({y_q[13:0], y_q[15:14]}),   .b(x_new),           .y(y_new));
    speck_xor16 u_xor_l (.a(l_sum),                     .b({11'd0, r_q}),    .y(l_new));
    speck_xor16 u_xor_k (.a({k_q[13:0], k_q[15:14]}),   .b(l_new),           .y(k_new));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        l0_d    = l0_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = pt_x;
                    y_d     = pt_y;
                    k_d     = key[15:0];
                    l0_d    = key[31:16];
                    l1_d    = key[47:32];
                    l2_d    = key[63:48];
                    r_d     = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d  = x_new;
                y_d  = y_new;
                k_d  = k_new;
                l0_d = l1_q;
                l1_d = l2_q;
                l2_d = l_new;
                r_d  = r_q + 5'd1;
                if (r_q == LAST_ROUND) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            r_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            r_q     <= r_d;
        end
    end

    // Handshakes decode only the registered state, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ct_x      = x_q;
    assign ct_y      = y_q;

`ifdef SPECK_ROUND_IDX_EN
    // r_q has already stepped to 22 when DONE is entered.
    assign round_idx = (state_q == IDLE) ? 5'd0 : r_q;
`endif

endmodule

// File: tb/tb_speck32_iter_core.sv
// Self-checking bench for speck32_iter_core: KAT, backpressure, busy-ignore, mid-run reset,
// back-to-back and random vectors against a loop-based Speck32/64 model.

module tb_speck32_iter_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pt_x;
    logic [15:0] pt_y;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ct_x;
    logic [15:0] ct_y;
`ifdef SPECK_ROUND_IDX_EN
    logic [4:0]  round_idx;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [15:0] KAT_PX  = 16'h6574;
    localparam logic [15:0] KAT_PY  = 16'h694C;
    localparam logic [15:0] KAT_CX  = 16'hA868;
    localparam logic [15:0] KAT_CY  = 16'h42F2;

    speck32_iter_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_x      (ct_x),
        .ct_y      (ct_y)
`ifdef SPECK_ROUND_IDX_EN
        ,
        .round_idx (round_idx)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
        int t = int'(v);
        return 16'(((t >> n) | (t << (16 - n))) & 32'hFFFF);
    endfunction

    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        return 16'((int'(a) + int'(b)) % 65536);
    endfunction

    // Textbook Speck32/64: key words expanded into an l[] array, 22 rounds.
    function automatic logic [31:0] speck_ref(input logic [15:0] px, input logic [15:0] py,
                                              input logic [63:0] kk);
        logic [15:0] x, y, k;
        logic [15:0] l [0:24];
        x = px;
        y = py;
        k = kk[15:0];
        l[0] = kk[31:16];
        l[1] = kk[47:32];
        l[2] = kk[63:48];
        for (int i = 0; i < 22; i++) begin
            x = add16(ror16(x, 7), y) ^ k;
            y = ror16(y, 14) ^ x;
            l[i + 3] = add16(k, ror16(l[i], 7)) ^ 16'(i);
            k = ror16(k, 14) ^ l[i + 3];
        end
        return {x, y};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation and clock it in; caller sits 1 time unit after the accept edge.
    task automatic start(input logic [15:0] px, input logic [15:0] py, input logic [63:0] kk);
        pt_x     = px;
        pt_y     = py;
        key      = kk;
        in_valid = 1'b1;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; returns cycles elapsed since the accept edge.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
`ifdef SPECK_ROUND_IDX_EN
            check("round_idx_run", 32'(round_idx), 32'(n));
`endif
            step();
            n++;
        end
        check("latency", 32'(n), 32'd22);
    endtask

    initial begin
        int          n;
        logic [31:0] exp;
        logic [15:0] hold_x, hold_y;
        logic [15:0] rx, ry;
        logic [63:0] rk;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt_x      = '0;
        pt_y      = '0;
        key       = '0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ct_x",      32'(ct_x),      32'd0);
        check("rst_ct_y",      32'(ct_y),      32'd0);
`ifdef SPECK_ROUND_IDX_EN
        check("rst_round_idx", 32'(round_idx), 32'd0);
`endif
        step();
        rst = 1'b0;

        // Known-answer test with backpressure held for 10 cycles in DONE.
        start(KAT_PX, KAT_PY, KAT_KEY);
        check("run_in_ready", 32'(in_ready), 32'd0);
        wait_done(n);
        check("kat_ct_x", 32'(ct_x), 32'(KAT_CX));
        check("kat_ct_y", 32'(ct_y), 32'(KAT_CY));
`ifdef SPECK_ROUND_IDX_EN
        check("round_idx_done", 32'(round_idx), 32'd22);
`endif
        hold_x = ct_x;
        hold_y = ct_y;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_ct_x",      32'(ct_x),      32'(hold_x));
            check("bp_ct_y",      32'(ct_y),      32'(hold_y));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready",  32'(in_ready),  32'd1);
`ifdef SPECK_ROUND_IDX_EN
        check("round_idx_idle", 32'(round_idx), 32'd0);
`endif

        // Busy: new in_valid and changing data during RUN must be ignored.
        start(KAT_PX, KAT_PY, KAT_KEY);
        in_valid = 1'b1;
        pt_x     = 16'($urandom);
        pt_y     = 16'($urandom);
        key      = {$urandom, $urandom};
        wait_done(n);
        in_valid = 1'b0;
        check("busy_ct_x", 32'(ct_x), 32'(KAT_CX));
        check("busy_ct_y", 32'(ct_y), 32'(KAT_CY));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset pulse in the middle of round 10.
        start(KAT_PX, KAT_PY, KAT_KEY);
        repeat (10) step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_ct_x",      32'(ct_x),      32'd0);
        check("mid_rst_ct_y",      32'(ct_y),      32'd0);
`ifdef SPECK_ROUND_IDX_EN
        check("mid_rst_round_idx", 32'(round_idx), 32'd0);
`endif
        step();
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        start(KAT_PX, KAT_PY, KAT_KEY);
        wait_done(n);
        check("post_rst_ct_x", 32'(ct_x), 32'(KAT_CX));
        check("post_rst_ct_y", 32'(ct_y), 32'(KAT_CY));
        out_ready = 1'b1;
        step();

        // Back-to-back with out_ready tied high: KAT then a random vector.
        rx = 16'($urandom);
        ry = 16'($urandom);
        rk = {$urandom, $urandom};
        start(KAT_PX, KAT_PY, KAT_KEY);
        wait_done(n);
        check("b2b1_ct_x", 32'(ct_x), 32'(KAT_CX));
        check("b2b1_ct_y", 32'(ct_y), 32'(KAT_CY));
        pt_x     = rx;
        pt_y     = ry;
        key      = rk;
        in_valid = 1'b1;
        step();
        check("b2b_idle_in_ready",  32'(in_ready),  32'd1);
        check("b2b_idle_out_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("b2b2_accepted", 32'(in_ready), 32'd0);
        wait_done(n);
        exp = speck_ref(rx, ry, rk);
        check("b2b2_ct_x", 32'(ct_x), 32'(exp[31:16]));
        check("b2b2_ct_y", 32'(ct_y), 32'(exp[15:0]));
        step();

        // Random vectors against the reference model.
        for (int v = 0; v < 6; v++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rk = {$urandom, $urandom};
            start(rx, ry, rk);
            wait_done(n);
            exp = speck_ref(rx, ry, rk);
            check("rand_ct_x", 32'(ct_x), 32'(exp[31:16]));
            check("rand_ct_y", 32'(ct_y), 32'(exp[15:0]));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
